disp_sched: RTL and testbench
=============================

# disp_sched

Display scheduler for the 8-digit seven-segment panel. It time-multiplexes the digits and shares the panel between two requesters: the main source (stopwatch/counter value) and a one-shot overlay source (messages, settings). Both are arbitrated at frame boundaries, so a frame never mixes sources. It sits between the counter/control logic and the board pins `led_en` and `led_cx`.

## Interface
Parameters:
- `time_max`, default 99_999: digit dwell is `time_max+1` clocks. At 100 MHz this gives 1 ms per digit.
- `ovl_frames`, default 250: number of full frames an accepted overlay occupies the panel (must be ≥1).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  master display enable (SW0).
- `main_data`  in  32  main source, 8 hex nibbles; nibble i drives digit i, digit 0 is rightmost.
- `main_mask`  in  8  per-digit enable for the main source; 1 = shown.
- `blank_lz`  in  1  leading-zero blanking for the main source.
- `ovl_req`  in  1  overlay request, a level held until `ovl_ack`.
- `ovl_data`  in  32  overlay content; sampled only at acceptance.
- `ovl_ack`  out  1  single-cycle pulse when the overlay is accepted.
- `ovl_busy`  out  1  high while the overlay owns the panel.
- `frame_tick`  out  1  single-cycle pulse at each frame boundary.
- `led_en`  out  8  digit enables, active-low.
- `led_cx`  out  8  segments `{a,b,c,d,e,f,g,dp}`, active-low; dp is always off (1).

## Operation
- **Divider.** `cnt` counts 0..`time_max`. A `tick` occurs when `cnt==time_max`. On `tick`, `dig` advances 0→7 and then wraps to 0.
- **Frame boundary.** A boundary is a `tick` with `dig==7`. At each boundary:
  - `frame_tick` pulses.
  - The arbiter updates.
  - The snapshot registers `snap_data` and `snap_mask` reload from the winning source.
- **Arbiter FSM, states MAIN and OVL.**
  - MAIN, boundary, `ovl_req=1`: capture `ovl_data` with mask 8'hFF and no blanking. Pulse `ovl_ack`, set `left=ovl_frames-1`, go to OVL.
  - MAIN, boundary, `ovl_req=0`: snapshot from `main_data`/`main_mask`, apply blanking, stay in MAIN.
  - OVL, boundary, `left>0`: decrement `left`. The snapshot is held.
  - OVL, boundary, `left==0`, `ovl_req=1`: accept the new overlay back-to-back (ack, reload) and stay in OVL.
  - OVL, boundary, `left==0`, `ovl_req=0`: snapshot main and go to MAIN.
- **Blanking.** When `blank_lz=1`, main digits above the highest nonzero nibble are masked off. Digit 0 is never blanked by this rule. All-zero data therefore shows a single "0".
- **Digit drive.** For the current `dig`, if `snap_mask[dig]` is set: `led_en=~(1<<dig)` and `led_cx=seg(snap_data[4*dig+:4])`. If the mask bit is clear: `led_en=8'hFF`, `led_cx=8'hFF`.
- **Decode.** Full hex 0–F. Examples: 0→8'h03, 1→8'h9F, 3→8'h0D, 8→8'h01, A→8'h11.
- **Disable (`en=0`).**
  - `led_en=8'hFF`, `led_cx=8'hFF`.
  - `cnt` and `dig` are held at 0, and no boundaries occur.
  - The arbiter is frozen and `ovl_req` is not accepted.
  - In MAIN, the snapshot reloads from main every cycle.
- **Re-enable.** Scan resumes at digit 0 with `cnt=0`. An OVL in progress keeps its `left`.

## Timing
- **Reset values.** `cnt=0`, `dig=0`, state MAIN, `left=0`, `snap_data=0`, `snap_mask=0`, `led_en=8'hFF`, `led_cx=8'hFF`, `ovl_ack=0`, `ovl_busy=0`, `frame_tick=0`.
- **Output latency.** `led_en` and `led_cx` are registered, with 1 cycle latency from a `dig` or snapshot change.
- **Frame period.** `8*(time_max+1)` clocks. Each digit is lit for exactly `time_max+1` consecutive cycles.
- **Boundary pulses.** `frame_tick` and `ovl_ack` are registered and assert in the cycle after the boundary edge.
- **`ovl_busy`.** Rises with `ovl_ack`. Falls one cycle after the returning boundary.
- **`ovl_req` rules.**
  - A request arriving mid-frame waits, at most one frame, for the next boundary.
  - The requester must drop `ovl_req` after `ack`, otherwise it is re-accepted at expiry.
- **Input sampling.** `main_data` changes mid-frame are invisible until the next boundary (no tearing).
- **Reset mid-operation.** `rst_n=0` at any cycle gives the full reset state at the next edge, and an overlay in progress is abandoned.

## Structure
- **Package `disp_pkg`:**
  - state enum `{MAIN, OVL}`
  - `LED_OFF = 8'hFF`
  - 16-entry active-low segment table
  - `seg` function
- **Sub-module `hex_to_seg`:** combinational 4→8 decoder using the `disp_pkg` table.
- **Top:** divider, scan counter, arbiter FSM, snapshot and blanking logic, output registers.

## Test plan
All scenarios use `time_max=3` (4-cycle dwell, 32-cycle frame) and `ovl_frames=2`.
- **Reset and blanking.** Reset, then `en=1`, `main_data=32'h3`, `main_mask=8'hFF`, `blank_lz=1`.
  - After the first boundary, digit 0 shows `led_en=8'hFE`, `led_cx=8'h0D` for 4 cycles.
  - Digits 1–7 show `led_en=8'hFF`.
- **No tearing.** Change `main_data` from 32'h12345678 to 32'h0 at digit 3 mid-frame.
  - The current frame finishes showing 8,7,6,5,4,3,2,1 (`led_cx` for digit 0 = decode of 8).
  - The new value appears only after `frame_tick`.
- **Overlay acceptance.** Pulse `ovl_req` with `ovl_data=32'hAAAAAAAA`, drop it on `ack`.
  - `ovl_ack` is one cycle, the cycle after the boundary.
  - `ovl_busy` is high for 64 cycles and all digits show `led_cx=8'h11`.
  - Main content returns afterwards.
- **Back-to-back overlay.** Hold `ovl_req` through expiry.
  - A second `ovl_ack` arrives exactly 64 cycles after the first.
  - `ovl_busy` never drops.
- **Disable mid-frame.** Take `en` low mid-frame.
  - Next cycle: `led_en=8'hFF`, `led_cx=8'hFF`, and no `frame_tick` while low.
  - On re-enable, digit 0 is lit 1 cycle later.
- **Reset mid-overlay.** Assert `rst_n=0` during an overlay.
  - Next edge: `ovl_busy=0`, `led_en=8'hFF`, `led_cx=8'hFF`, state MAIN.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and the seven-segment font for the display scheduler.
package disp_pkg;

  typedef enum logic [0:0] {
    Main,
    Ovl
  } arb_state_e;

  localparam logic [7:0] LED_OFF = 8'hFF;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is always off. Index 15 is leftmost.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic logic [7:0] seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg(nibble_i);

endmodule

// File: rtl/disp_sched.sv
// Eight-digit multiplexed display scheduler arbitrating a main source and a
// one-shot overlay at frame boundaries.
module disp_sched
  import disp_pkg::*;
#(
  parameter int unsigned time_max   = 99_999,
  parameter int unsigned ovl_frames = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] main_data,
  input  logic [7:0]  main_mask,
  input  logic        blank_lz,
  input  logic        ovl_req,
  input  logic [31:0] ovl_data,
  output logic        ovl_ack,
  output logic        ovl_busy,
  output logic        frame_tick,
  output logic [7:0]  led_en,
  output logic [7:0]  led_cx
);

  localparam int unsigned CntW  = (time_max > 0) ? $clog2(time_max + 1) : 1;
  localparam int unsigned LeftW = (ovl_frames > 1) ? $clog2(ovl_frames) : 1;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  arb_state_e       state_q, state_d;
  logic [LeftW-1:0] left_q, left_d;
  logic [31:0]      snap_data_q, snap_data_d;
  logic [7:0]       snap_mask_q, snap_mask_d;
  logic [7:0]       led_en_q, led_en_d, led_cx_q, led_cx_d;
  logic             ack_q, busy_q, busy_d, tick_q;

  logic       tick, boundary, accept, load_main;
  logic [7:0] lz_mask, main_mask_eff, digit_seg;

  assign tick     = en && (cnt_q == CntW'(time_max));
  assign boundary = tick && (dig_q == 3'd7);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    dig_d = dig_q;
    if (!en) begin
      cnt_d = '0;
      dig_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      dig_d = dig_q + 3'd1;
    end
  end

  // A digit survives blanking if it or any more significant nibble is nonzero.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_mask = 8'h01;
    for (int i = 7; i >= 1; i--) begin
      seen       = seen | (|main_data[4*i +: 4]);
      lz_mask[i] = seen;
    end
    main_mask_eff = main_mask & (blank_lz ? lz_mask : 8'hFF);
  end

  // Arbiter next state.
  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    accept    = 1'b0;
    load_main = 1'b0;
    if (!en) begin
      load_main = (state_q == Main);
    end else if (boundary) begin
      unique case (state_q)
        Main: begin
          if (ovl_req) begin
            accept  = 1'b1;
            left_d  = LeftW'(ovl_frames - 1);
            state_d = Ovl;
          end else begin
            load_main = 1'b1;
          end
        end
        Ovl: begin
          if (left_q != '0) begin
            left_d = left_q - LeftW'(1);
          end else if (ovl_req) begin
            accept = 1'b1;
            left_d = LeftW'(ovl_frames - 1);
          end else begin
            load_main = 1'b1;
            state_d   = Main;
          end
        end
      endcase
    end
  end

  always_comb begin
    snap_data_d = snap_data_q;
    snap_mask_d = snap_mask_q;
    if (accept) begin
      snap_data_d = ovl_data;
      snap_mask_d = 8'hFF;
    end else if (load_main) begin
      snap_data_d = main_data;
      snap_mask_d = main_mask_eff;
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble_i (snap_data_q[4*dig_q +: 4]),
    .seg_o    (digit_seg)
  );

  // Outputs.
  always_comb begin
    led_en_d = LED_OFF;
    led_cx_d = LED_OFF;
    busy_d   = (state_d == Ovl);
    if (en && snap_mask_q[dig_q]) begin
      led_en_d = ~(8'h01 << dig_q);
      led_cx_d = digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      state_q     <= Main;
      left_q      <= '0;
      snap_data_q <= '0;
      snap_mask_q <= '0;
      led_en_q    <= LED_OFF;
      led_cx_q    <= LED_OFF;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      state_q     <= state_d;
      left_q      <= left_d;
      snap_data_q <= snap_data_d;
      snap_mask_q <= snap_mask_d;
      led_en_q    <= led_en_d;
      led_cx_q    <= led_cx_d;
      ack_q       <= accept;
      busy_q      <= busy_d;
      tick_q      <= boundary;
    end
  end

  assign ovl_ack    = ack_q;
  assign ovl_busy   = busy_q;
  assign frame_tick = tick_q;
  assign led_en     = led_en_q;
  assign led_cx     = led_cx_q;

endmodule

// File: tb/tb_disp_sched.sv
// Randomised scoreboard bench for disp_sched against a frame-level reference model.
module tb_disp_sched;

  localparam int unsigned D     = 4;
  localparam int unsigned F     = 2;
  localparam int unsigned FRAME = 8 * D;

  logic        clk = 1'b0;
  logic        rst_n, en, blank_lz, ovl_req;
  logic [31:0] main_data, ovl_data;
  logic [7:0]  main_mask;
  logic        ovl_ack, ovl_busy, frame_tick;
  logic [7:0]  led_en, led_cx;

  disp_sched #(
    .time_max   (D - 1),
    .ovl_frames (F)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .main_data  (main_data),
    .main_mask  (main_mask),
    .blank_lz   (blank_lz),
    .ovl_req    (ovl_req),
    .ovl_data   (ovl_data),
    .ovl_ack    (ovl_ack),
    .ovl_busy   (ovl_busy),
    .frame_tick (frame_tick),
    .led_en     (led_en),
    .led_cx     (led_cx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] cx;
    logic       ack;
    logic       busy;
    logic       tick;
  } obs_t;

  obs_t exp_q[$];
  int   ack_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Segment font as lit-segment letters, converted to active-low codes.
  string font[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [7:0] font_code(input int n);
    logic [7:0] code;
    int         idx;
    code = 8'hFF;
    for (int k = 0; k < font[n].len(); k++) begin
      idx = int'(font[n].getc(k)) - 97;
      code[7 - idx] = 1'b0;
    end
    return code;
  endfunction

  // Reference model: scan position within the frame, overlay frames remaining,
  // and the digit content frozen for the current frame.
  int         pos;
  bit         in_ovl;
  int         frames_left;
  logic [3:0] snap_nib[8];
  bit         snap_on[8];

  function automatic void take_main();
    int top;
    top = 0;
    for (int i = 0; i < 8; i++) if (main_data[4*i +: 4] != 4'd0) top = i;
    for (int i = 0; i < 8; i++) begin
      snap_nib[i] = main_data[4*i +: 4];
      snap_on[i]  = main_mask[i] && (!blank_lz || i <= top);
    end
  endfunction

  always @(posedge clk) begin
    obs_t       e;
    int         d;
    logic [7:0] one;
    one = 8'h01;
    cyc++;
    e = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    if (!rst_n) begin
      pos         = 0;
      in_ovl      = 0;
      frames_left = 0;
      for (int i = 0; i < 8; i++) begin
        snap_nib[i] = 4'd0;
        snap_on[i]  = 0;
      end
    end else if (!en) begin
      pos = 0;
      if (!in_ovl) take_main();
      e.busy = in_ovl;
    end else begin
      d = pos / D;
      if (snap_on[d]) begin
        e.en = ~(one << d);
        e.cx = font_code(int'(snap_nib[d]));
      end
      if (pos == FRAME - 1) begin
        e.tick = 1'b1;
        if (in_ovl && frames_left > 0) begin
          frames_left--;
        end else if (ovl_req) begin
          in_ovl      = 1;
          frames_left = F - 1;
          e.ack       = 1'b1;
          ack_q.push_back(cyc);
          for (int i = 0; i < 8; i++) begin
            snap_nib[i] = ovl_data[4*i +: 4];
            snap_on[i]  = 1;
          end
        end else begin
          in_ovl = 0;
          take_main();
        end
      end
      pos    = (pos + 1) % FRAME;
      e.busy = in_ovl;
    end
    exp_q.push_back(e);
  end

  // Monitor: every cycle presents a display word; acks are matched by cycle.
  always @(negedge clk) begin
    obs_t a, e;
    int   t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {led_en, led_cx, ovl_ack, ovl_busy, frame_tick};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d: got en=%h cx=%h ack=%b busy=%b tick=%b, want en=%h cx=%h ack=%b busy=%b tick=%b",
                 cyc, a.en, a.cx, a.ack, a.busy, a.tick, e.en, e.cx, e.ack, e.busy, e.tick);
      end
    end
    if (ovl_ack === 1'b1) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected cyc=%0d: got ack, want none", cyc);
      end else begin
        t = ack_q.pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL ack_cycle: got cyc=%0d, want cyc=%0d", cyc, t);
        end
      end
    end else if (ack_q.size() > 0 && ack_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL ack_missed: got none, want ack at cyc=%0d", ack_q[0]);
      void'(ack_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ovl_ack) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack in 200 cycles, want one");
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no frame_tick in 100 cycles, want one");
    end
  endtask

  initial begin
    int t1, t2, n;
    bit dropped;
    rst_n     = 1'b0;
    en        = 1'b0;
    main_data = '0;
    main_mask = '0;
    blank_lz  = 1'b0;
    ovl_req   = 1'b0;
    ovl_data  = '0;
    step(3);

    // Leading-zero blanking of a single digit.
    rst_n     = 1'b1;
    en        = 1'b1;
    main_data = 32'h3;
    main_mask = 8'hFF;
    blank_lz  = 1'b1;
    step(80);

    // Mid-frame change must not tear.
    main_data = 32'h12345678;
    blank_lz  = 1'b0;
    wait_tick();
    wait_tick();
    step(13);
    main_data = 32'h0;
    step(70);

    // Single overlay; busy spans exactly two frames.
    main_data = 32'h00C0FFEE;
    blank_lz  = 1'b1;
    ovl_data  = 32'hAAAAAAAA;
    ovl_req   = 1'b1;
    wait_ack(t1);
    ovl_req = 1'b0;
    n = 0;
    while (ovl_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles, want 64", n);
    end
    step(60);

    // Back-to-back overlay with request held through expiry.
    ovl_data = 32'h01234567;
    ovl_req  = 1'b1;
    wait_ack(t1);
    t2      = -1;
    dropped = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ovl_busy) dropped = 1;
      if (ovl_ack) begin
        t2 = cyc;
        break;
      end
    end
    ovl_req = 1'b0;
    checks++;
    if (t2 - t1 != 64) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, want 64", t2 - t1);
    end
    checks++;
    if (dropped) begin
      errors++;
      $display("FAIL b2b_busy: got busy drop, want busy held");
    end
    step(100);

    // Disable mid-frame and re-enable.
    step(10);
    en = 1'b0;
    step(20);
    en = 1'b1;
    step(40);

    // Reset while an overlay owns the panel.
    ovl_data = 32'hFEDCBA98;
    ovl_req  = 1'b1;
    wait_ack(t1);
    ovl_req = 1'b0;
    step(20);
    rst_n = 1'b0;
    step(1);
    checks++;
    if (ovl_busy !== 1'b0 || led_en !== 8'hFF || led_cx !== 8'hFF) begin
      errors++;
      $display("FAIL reset_ovl: got busy=%b en=%h cx=%h, want busy=0 en=ff cx=ff",
               ovl_busy, led_en, led_cx);
    end
    rst_n = 1'b1;
    step(40);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 39) == 0) main_data = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 99) == 0) main_mask = 8'($urandom);
      if ($urandom_range(0, 149) == 0) blank_lz = ~blank_lz;
      if (en) begin
        if ($urandom_range(0, 299) == 0) en = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        en = 1'b1;
      end
      if (ovl_req && ovl_ack && $urandom_range(0, 3) != 0) ovl_req = 1'b0;
      else if (!ovl_req && $urandom_range(0, 99) == 0) ovl_req = 1'b1;
      if (ovl_req) ovl_data = $urandom;
    end
    rst_n = 1'b1;
    step(5);

    checks++;
    if (ack_q.size() != 0) begin
      errors++;
      $display("FAIL ack_leftover: got %0d pending, want 0", ack_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
